fwd_hazard_ctrl: RTL and testbench

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_hazard_ctrl.sv | 97 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding select, load-use stall and redirect bubble control with saturating event counters
module fwd_hazard_ctrl #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            ex_redirect,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            stall,
  output logic            bubble_ex,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);
  logic            ex_valid_q, ex_valid_d, ex_regwrite_q, ex_regwrite_d, ex_memread_q, ex_memread_d;
  logic [4:0]      ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic            mem_valid_q, mem_valid_d, mem_regwrite_q, mem_regwrite_d;
  logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic            load_use;
  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs);
    if (!use_rs || rs == 5'd0) return 2'b00;
    if (ex_valid_q && ex_regwrite_q && !ex_memread_q && ex_rd_q == rs) return 2'b10;
    if (mem_valid_q && mem_regwrite_q && mem_rd_q == rs) return 2'b01;
    return 2'b00;
  endfunction
  assign load_use = id_valid && ex_valid_q && ex_memread_q && ex_regwrite_q && ex_rd_q != 5'd0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd_q) || (id_use_rs2 && id_rs2 == ex_rd_q));
  assign stall     = load_use && !hold;
  assign bubble_ex = (load_use || ex_redirect) && !hold;
  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memread_d   = ex_memread_q;
    mem_valid_d    = mem_valid_q;
    mem_rd_d       = mem_rd_q;
    mem_regwrite_d = mem_regwrite_q;
    fwd_a_d        = fwd_a_q;
    fwd_b_d        = fwd_b_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    if (!hold) begin
      mem_valid_d    = ex_valid_q;
      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      ex_valid_d     = bubble_ex ? 1'b0 : id_valid;
      ex_rd_d        = bubble_ex ? 5'd0 : id_rd;
      ex_regwrite_d  = bubble_ex ? 1'b0 : id_regwrite;
      ex_memread_d   = bubble_ex ? 1'b0 : id_memread;
      fwd_a_d        = bubble_ex ? 2'b00 : fwd_sel(id_use_rs1, id_rs1);
      fwd_b_d        = bubble_ex ? 2'b00 : fwd_sel(id_use_rs2, id_rs2);
      stall_cnt_d    = (stall && !ex_redirect && !(&stall_cnt_q)) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;
      flush_cnt_d    = (ex_redirect && !(&flush_cnt_q)) ? flush_cnt_q + CNTW'(1) : flush_cnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= 5'd0;
      mem_regwrite_q <= 1'b0;
      fwd_a_q        <= 2'b00;
      fwd_b_q        <= 2'b00;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed and random stimulus scored against a history-queue reference model
module tb_fwd_hazard_ctrl;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } instr_t;
  typedef struct {
    bit stall;
    bit bubble;
    int fa;
    int fb;
    int sc;
    int fc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, hold = 1'b0, id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, ex_redirect = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic stall, bubble_ex;
  logic [CNTW-1:0] stall_cnt, flush_cnt;
  int tests = 0, fails = 0;
  exp_t sb[$];
  instr_t pipe[$];
  int m_fa = 0, m_fb = 0, m_sc = 0, m_fc = 0;
  fwd_hazard_ctrl #(.CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_redirect(ex_redirect),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .bubble_ex(bubble_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  function automatic int src(bit u, int rs, instr_t older1, instr_t older2);
    if (!u || rs == 0) return 0;
    if (older1.v && older1.rw && !older1.mr && older1.rd == rs) return 2;
    if (older2.v && older2.rw && older2.rd == rs) return 1;
    return 0;
  endfunction
  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic model_reset();
    pipe.delete();
    pipe.push_back('{0, 0, 0, 0});
    pipe.push_back('{0, 0, 0, 0});
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endtask
  task automatic step(bit r, bit h, bit v, int rs1, int rs2, int rd, bit u1, bit u2, bit rw, bit mr, bit redir);
    exp_t e;
    instr_t ex1, ex2;
    bit lu;
    @(negedge clk);
    rst = r; hold = h; id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_memread = mr; ex_redirect = redir;
    ex1 = pipe[0];
    ex2 = pipe[1];
    lu = v && ex1.v && ex1.mr && ex1.rw && ex1.rd != 0 && ((u1 && rs1 == ex1.rd) || (u2 && rs2 == ex1.rd));
    e.stall = lu && !h;
    e.bubble = (lu || redir) && !h;
    e.fa = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    if (r) model_reset();
    else if (!h) begin
      m_fa = e.bubble ? 0 : src(u1, rs1, ex1, ex2);
      m_fb = e.bubble ? 0 : src(u2, rs2, ex1, ex2);
      if (lu && !redir && m_sc < CMAX) m_sc++;
      if (redir && m_fc < CMAX) m_fc++;
      pipe.pop_back();
      if (e.bubble) pipe.push_front('{0, 0, 0, 0});
      else pipe.push_front('{v, rd, rw, mr});
    end
  endtask
  task automatic nop(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall", int'(stall), int'(e.stall));
        check("bubble_ex", int'(bubble_ex), int'(e.bubble));
        check("fwd_a_sel", int'(fwd_a_sel), e.fa);
        check("fwd_b_sel", int'(fwd_b_sel), e.fb);
        check("stall_cnt", int'(stall_cnt), e.sc);
        check("flush_cnt", int'(flush_cnt), e.fc);
      end
    end
  end
  initial begin : stim
    model_reset();
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // add x5 ; add x6,x5,x7
    step(0, 0, 1, 1, 2, 5, 1, 1, 1, 0, 0);
    step(0, 0, 1, 5, 7, 6, 1, 1, 1, 0, 0);
    nop(3);
    // lw x5 ; add x6,x7,x5 held in ID for one stall cycle
    step(0, 0, 1, 1, 0, 5, 1, 0, 1, 1, 0);
    step(0, 0, 1, 7, 5, 6, 1, 1, 1, 0, 0);
    step(0, 0, 1, 7, 5, 6, 1, 1, 1, 0, 0);
    nop(3);
    // writes to x0, then uses of x0
    step(0, 0, 1, 1, 2, 0, 1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 6, 1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0, 6, 1, 1, 1, 0, 0);
    nop(3);
    // addi with stale rs2 field matching EX.rd
    step(0, 0, 1, 1, 2, 5, 1, 1, 1, 0, 0);
    step(0, 0, 1, 3, 5, 8, 1, 0, 1, 0, 0);
    nop(3);
    // load-use coincident with redirect, then hold for 3 cycles
    step(0, 0, 1, 1, 0, 5, 1, 0, 1, 1, 0);
    step(0, 0, 1, 5, 2, 6, 1, 1, 1, 0, 1);
    step(0, 0, 1, 6, 6, 7, 1, 1, 1, 0, 0);
    step(0, 1, 1, 7, 6, 8, 1, 1, 1, 1, 1);
    step(0, 1, 1, 7, 6, 8, 1, 1, 1, 1, 1);
    step(0, 1, 1, 7, 6, 8, 1, 1, 1, 1, 0);
    step(0, 0, 1, 7, 6, 8, 1, 1, 1, 0, 0);
    nop(2);
    // saturate stall_cnt with repeated load-use pairs
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 1, 0, 9, 1, 0, 1, 1, 0);
      step(0, 0, 1, 9, 0, 10, 1, 0, 1, 0, 0);
    end
    // reset in the middle of a stall
    step(0, 0, 1, 1, 0, 5, 1, 0, 1, 1, 0);
    step(1, 0, 1, 5, 0, 6, 1, 0, 1, 0, 0);
    step(0, 0, 1, 5, 5, 6, 1, 1, 1, 0, 0);
    nop(2);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #3;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, 0 expected", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
